flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit_pkg.sv | 19 +
 rtl/flag_unit_calc.sv | 27 ++
 rtl/flag_unit.sv | 68 ++++++
 tb/tb_flag_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/flag_unit_pkg.sv
// Shared flag-bus layout, also used by the condition checker.
package flag_unit_pkg;

   localparam int unsigned FLAG_W = 4;
   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_V = 3;
   localparam int unsigned DATA_W = 32;

   // Member order matches the bit indices above (z is bit 0).
   typedef struct packed {
      logic v;
      logic n;
      logic c;
      logic z;
   } flags_t;

endpackage

// File: rtl/flag_unit_calc.sv
// Combinational NZCV computation for one instruction result.
module flag_calc
   import flag_unit_pkg::*;
(
   input  logic [DATA_W-1:0] result,
   input  logic              alu_c,
   input  logic              alu_v,
   input  logic              shc,
   input  logic              arith,
   input  logic              prev_v,
   output logic [FLAG_W-1:0] flags
);

   flags_t f;

   // Logical ops take carry from the shifter and keep the forwarded V.
   always_comb begin
      f   = '0;
      f.z = (result == '0);
      f.n = result[DATA_W-1];
      f.c = arith ? alu_c : shc;
      f.v = arith ? alu_v : prev_v;
   end

   assign flags = f;

endmodule

// File: rtl/flag_unit.sv
// Two-stage flag pipeline: pending update register then committed CPSR flags.
module flag_unit
   import flag_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic              setflags_in,
   input  logic              arith_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic              alu_c_in,
   input  logic              alu_v_in,
   input  logic              shc_in,
   input  logic              msr_en_in,
   input  logic [FLAG_W-1:0] msr_data_in,
   input  logic              stall_in,
   input  logic              flush_in,
   output logic [FLAG_W-1:0] cpsr_out,
   output logic [FLAG_W-1:0] cpsr_fwd_out,
   output logic              pend_valid_out
);

   logic [FLAG_W-1:0] pend_flags;
   logic              pend_valid;
   logic [FLAG_W-1:0] cpsr_q;
   logic [FLAG_W-1:0] calc_flags;
   logic              load;

   assign cpsr_fwd_out   = pend_valid ? pend_flags : cpsr_q;
   assign cpsr_out       = cpsr_q;
   assign pend_valid_out = pend_valid;

   flag_calc u_calc (
      .result (result_in),
      .alu_c  (alu_c_in),
      .alu_v  (alu_v_in),
      .shc    (shc_in),
      .arith  (arith_in),
      .prev_v (cpsr_fwd_out[FLAG_V]),
      .flags  (calc_flags)
   );

   // An msr write takes the slot, so no capture happens alongside it.
   assign load = valid_in & setflags_in & ~stall_in & ~flush_in & ~msr_en_in;

   // Priority: reset > flush > msr > stall > commit/capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpsr_q     <= '0;
         pend_flags <= '0;
         pend_valid <= 1'b0;
      end else if (flush_in) begin
         pend_valid <= 1'b0;
      end else if (msr_en_in) begin
         cpsr_q     <= msr_data_in;
         pend_valid <= 1'b0;
      end else if (!stall_in) begin
         if (pend_valid) begin
            cpsr_q <= pend_flags;
         end
         pend_valid <= load;
         if (load) begin
            pend_flags <= calc_flags;
         end
      end
   end

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboarded random and directed test of flag_unit against a queue-based model.
module tb_flag_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in, setflags_in, arith_in;
   logic [31:0] result_in;
   logic        alu_c_in, alu_v_in, shc_in;
   logic        msr_en_in;
   logic [3:0]  msr_data_in;
   logic        stall_in, flush_in;
   logic [3:0]  cpsr_out, cpsr_fwd_out;
   logic        pend_valid_out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] cpsr;
      logic [3:0] fwd;
      logic       pv;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] m_cpsr;
   logic [3:0] m_pend[$];
   bit         done = 0;

   always #5 clk = ~clk;

   flag_unit dut (
      .clk            (clk),
      .reset          (reset),
      .valid_in       (valid_in),
      .setflags_in    (setflags_in),
      .arith_in       (arith_in),
      .result_in      (result_in),
      .alu_c_in       (alu_c_in),
      .alu_v_in       (alu_v_in),
      .shc_in         (shc_in),
      .msr_en_in      (msr_en_in),
      .msr_data_in    (msr_data_in),
      .stall_in       (stall_in),
      .flush_in       (flush_in),
      .cpsr_out       (cpsr_out),
      .cpsr_fwd_out   (cpsr_fwd_out),
      .pend_valid_out (pend_valid_out)
   );

   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
      end
   endtask

   // Reference: committed flags plus a queue holding at most one pending update.
   function automatic logic [3:0] fwd_of();
      return (m_pend.size() != 0) ? m_pend[0] : m_cpsr;
   endfunction

   task automatic tick();
      logic [3:0] fwd, nf;
      exp_t e;
      fwd = fwd_of();
      if (reset) begin
         m_cpsr = 4'b0000;
         m_pend.delete();
      end else if (flush_in) begin
         m_pend.delete();
      end else if (msr_en_in) begin
         m_cpsr = msr_data_in;
         m_pend.delete();
      end else if (!stall_in) begin
         if (m_pend.size() != 0) m_cpsr = m_pend.pop_front();
         if (valid_in && setflags_in) begin
            nf[0] = (result_in == 32'd0);
            nf[2] = result_in[31];
            nf[1] = arith_in ? alu_c_in : shc_in;
            nf[3] = arith_in ? alu_v_in : fwd[3];
            m_pend.push_back(nf);
         end
      end
      e.cpsr = m_cpsr;
      e.fwd  = fwd_of();
      e.pv   = (m_pend.size() != 0);
      sb.push_back(e);
      @(posedge clk);
      #3;
   endtask

   task automatic idle();
      reset = 0; valid_in = 0; setflags_in = 0; arith_in = 0; result_in = '0;
      alu_c_in = 0; alu_v_in = 0; shc_in = 0; msr_en_in = 0; msr_data_in = '0;
      stall_in = 0; flush_in = 0;
   endtask

   task automatic op(input logic ar, input logic [31:0] res, input logic c, input logic v,
                     input logic sh);
      idle();
      valid_in = 1; setflags_in = 1; arith_in = ar; result_in = res;
      alu_c_in = c; alu_v_in = v; shc_in = sh;
   endtask

   task automatic do_reset();
      idle(); reset = 1; tick(); idle();
   endtask

   // Monitor: every edge produces one observable state to compare.
   initial begin
      exp_t e;
      while (!done) begin
         @(posedge clk);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_cpsr", cpsr_out, e.cpsr);
            chk("sb_fwd", cpsr_fwd_out, e.fwd);
            chk("sb_pend_valid", {3'b0, pend_valid_out}, {3'b0, e.pv});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      m_cpsr = 4'b0000;
      idle();
      do_reset();
      chk("reset_cpsr", cpsr_out, 4'b0000);
      chk("reset_fwd", cpsr_fwd_out, 4'b0000);
      chk("reset_pv", {3'b0, pend_valid_out}, 4'b0000);

      // subs setting Z and C
      op(1, 32'd0, 1, 0, 0); tick();
      chk("subs_pv", {3'b0, pend_valid_out}, 4'b0001);
      chk("subs_fwd", cpsr_fwd_out, 4'b0011);
      idle(); tick();
      chk("subs_cpsr", cpsr_out, 4'b0011);

      // logical op keeps V written by msr
      idle(); msr_en_in = 1; msr_data_in = 4'b1000; tick();
      op(0, 32'h8000_0000, 0, 0, 1); tick();
      idle(); tick();
      chk("logic_cpsr", cpsr_out, 4'b1110);

      // flush squashes the load
      do_reset();
      op(1, 32'd0, 0, 0, 0); tick();
      idle(); flush_in = 1; tick();
      chk("flush_pv", {3'b0, pend_valid_out}, 4'b0000);
      chk("flush_cpsr", cpsr_out, 4'b0000);
      idle(); tick();
      chk("flush_cpsr2", cpsr_out, 4'b0000);

      // stall holds the pending update for three cycles
      op(1, 32'h0000_0005, 1, 1, 0); tick();
      for (int i = 0; i < 3; i++) begin
         idle(); stall_in = 1; tick();
         chk("stall_pv", {3'b0, pend_valid_out}, 4'b0001);
         chk("stall_cpsr", cpsr_out, 4'b0000);
      end
      idle(); tick();
      chk("stall_commit", cpsr_out, 4'b1010);
      chk("stall_pv_clr", {3'b0, pend_valid_out}, 4'b0000);

      // back-to-back Z then N
      do_reset();
      op(1, 32'd0, 0, 0, 0); tick();
      chk("b2b_fwd1", cpsr_fwd_out, 4'b0001);
      op(1, 32'h8000_0000, 0, 0, 0); tick();
      chk("b2b_fwd2", cpsr_fwd_out, 4'b0100);
      chk("b2b_cpsr1", cpsr_out, 4'b0001);
      idle(); tick();
      chk("b2b_cpsr2", cpsr_out, 4'b0100);

      // msr overrides a pending update
      op(1, 32'd0, 1, 1, 0); tick();
      idle(); msr_en_in = 1; msr_data_in = 4'b1010; tick();
      chk("msr_cpsr", cpsr_out, 4'b1010);
      chk("msr_pv", {3'b0, pend_valid_out}, 4'b0000);
      idle(); tick();
      chk("msr_dropped", cpsr_out, 4'b1010);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         idle();
         reset       = ($urandom_range(0, 49) == 0);
         valid_in    = ($urandom_range(0, 3) != 0);
         setflags_in = ($urandom_range(0, 3) != 0);
         arith_in    = 1'($urandom);
         result_in   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         alu_c_in    = 1'($urandom);
         alu_v_in    = 1'($urandom);
         shc_in      = 1'($urandom);
         msr_en_in   = ($urandom_range(0, 7) == 0);
         msr_data_in = 4'($urandom);
         stall_in    = ($urandom_range(0, 3) == 0);
         flush_in    = ($urandom_range(0, 9) == 0);
         tick();
      end

      idle(); tick();
      done = 1;
      @(posedge clk); #3;
      chk("sb_drained", 4'(sb.size()), 4'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
